memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage. Consumes the EX/MEM register contents and issues data-cache reads and writes.
- Holds the pipeline while a data access is outstanding.
- Resolves branch, jr and j/jal redirects.
- Registers the MEM/WB bundle consumed by writeback.

---
 rtl/memory_stage.sv | 199 +++++++++++++++++++
 tb/tb_memory_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute. Issues data-cache accesses,
// holds the pipeline while one is outstanding, resolves jr/j/jal/branch
// redirects and registers the MEM/WB bundle for writeback.
module memory_stage #(
    parameter int unsigned DW     = 32,
    parameter int unsigned RW     = 5,
    parameter int unsigned RA_REG = 31
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_valid,
    input  logic [DW-1:0] alu_out,
    input  logic          z_in,
    input  logic          bne_in,
    input  logic          branch_in,
    input  logic [DW-1:0] branch_addr,
    input  logic [DW-1:0] read_dat1,
    input  logic [DW-1:0] read_dat2,
    input  logic [RW-1:0] write_reg,
    input  logic          jr_flag,
    input  logic          j_jal_flag,
    input  logic          jal_flag,
    input  logic          lui_flag,
    input  logic          memtoreg,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          regWEN,
    input  logic          halt,
    input  logic [DW-1:0] j_jal_addr,
    input  logic [DW-1:0] lower_zero,
    input  logic [DW-1:0] pc4,
    input  logic [DW-1:0] instruction,
    input  logic          dhit,
    input  logic [DW-1:0] dmemload,
    output logic          dmemREN,
    output logic          dmemWEN,
    output logic [DW-1:0] dmemaddr,
    output logic [DW-1:0] dmemstore,
    output logic          mem_stall,
    output logic [1:0]    pc_sel,
    output logic [DW-1:0] pc_target,
    output logic          flush,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_reg,
    output logic          wb_wen,
    output logic          halt_out,
    output logic [DW-1:0] instruction_out,
    output logic [1:0]    state_dbg        // 0 = IDLE, 1 = ACCESS, 2 = HALTED
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state_q;

    // Access context captured when a load/store is accepted, so the
    // outstanding request and its writeback do not depend on the upstream
    // bundle staying put.
    logic [DW-1:0] addr_q;
    logic [DW-1:0] store_q;
    logic          rd_q;
    logic          wr_q;
    logic [RW-1:0] reg_q;
    logic          wen_q;
    logic          m2r_q;
    logic [DW-1:0] instr_q;

    logic [DW-1:0] wb_data_q;
    logic [RW-1:0] wb_reg_q;
    logic          wb_wen_q;
    logic          halt_q;
    logic [DW-1:0] instr_out_q;

    logic          in_access;
    logic          is_mem_op;
    logic          redirect_en;
    logic          branch_taken;
    logic [DW-1:0] wb_mux;
    logic [RW-1:0] wb_reg_mux;

    assign in_access    = (state_q == ACCESS);
    assign is_mem_op    = mem_read | mem_write;
    assign redirect_en  = in_valid & (state_q == IDLE) & ~is_mem_op;
    assign branch_taken = branch_in & (z_in ^ bne_in);

    // Writeback value/destination for a single-cycle (non-memory) instruction.
    always_comb begin
        wb_mux = alu_out;
        if (jal_flag)      wb_mux = pc4;
        else if (lui_flag) wb_mux = lower_zero;
        else if (memtoreg) wb_mux = dmemload;
        wb_reg_mux = jal_flag ? RW'(RA_REG) : write_reg;
    end

    // Redirect resolution: jr > j/jal > taken branch > fall-through.
    always_comb begin
        pc_sel    = 2'd0;
        pc_target = '0;
        if (redirect_en) begin
            pc_target = pc4;
            if (jr_flag) begin
                pc_sel    = 2'd2;
                pc_target = read_dat1;
            end else if (j_jal_flag) begin
                pc_sel    = 2'd3;
                pc_target = j_jal_addr;
            end else if (branch_taken) begin
                pc_sel    = 2'd1;
                pc_target = branch_addr;
            end
        end
    end

    assign flush     = (pc_sel != 2'd0);

    // Requests come only from the captured context while ACCESS is active.
    assign dmemREN   = in_access & rd_q;
    assign dmemWEN   = in_access & wr_q;
    assign dmemaddr  = in_access ? addr_q  : '0;
    assign dmemstore = in_access ? store_q : '0;
    assign mem_stall = in_access & ~dhit;

    assign wb_data         = wb_data_q;
    assign wb_reg          = wb_reg_q;
    assign wb_wen          = wb_wen_q;
    assign halt_out        = halt_q;
    assign instruction_out = instr_out_q;
    assign state_dbg       = state_q;

    // Stage FSM: accepts bundles, runs data accesses, latches MEM/WB.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            store_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            reg_q       <= '0;
            wen_q       <= 1'b0;
            m2r_q       <= 1'b0;
            instr_q     <= '0;
            wb_data_q   <= '0;
            wb_reg_q    <= '0;
            wb_wen_q    <= 1'b0;
            halt_q      <= 1'b0;
            instr_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && halt) begin
                        halt_q   <= 1'b1;
                        wb_wen_q <= 1'b0;
                        state_q  <= HALTED;
                    end else if (in_valid && is_mem_op) begin
                        addr_q   <= alu_out;
                        store_q  <= read_dat2;
                        rd_q     <= mem_read;
                        wr_q     <= mem_write & ~mem_read;  // read wins if both set
                        reg_q    <= write_reg;
                        wen_q    <= regWEN;
                        m2r_q    <= memtoreg;
                        instr_q  <= instruction;
                        wb_wen_q <= 1'b0;
                        state_q  <= ACCESS;
                    end else if (in_valid) begin
                        wb_data_q   <= wb_mux;
                        wb_reg_q    <= wb_reg_mux;
                        wb_wen_q    <= regWEN;
                        instr_out_q <= instruction;
                    end else begin
                        wb_wen_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        wb_data_q   <= m2r_q ? dmemload : addr_q;
                        wb_reg_q    <= reg_q;
                        wb_wen_q    <= wen_q;
                        instr_out_q <= instr_q;
                        state_q     <= IDLE;
                    end else begin
                        wb_wen_q <= 1'b0;
                    end
                end
                HALTED: begin
                    wb_wen_q <= 1'b0;
                    halt_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage. Inputs change on the falling edge,
// outputs are sampled on the falling edge or 1ns after input changes.
`timescale 1ns/1ps
module tb_memory_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic [31:0] alu_out;
    logic        z_in, bne_in, branch_in;
    logic [31:0] branch_addr, read_dat1, read_dat2;
    logic [4:0]  write_reg;
    logic        jr_flag, j_jal_flag, jal_flag, lui_flag, memtoreg;
    logic        mem_read, mem_write, regWEN, halt;
    logic [31:0] j_jal_addr, lower_zero, pc4, instruction;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall, flush, wb_wen, halt_out;
    logic [31:0] dmemaddr, dmemstore, pc_target, wb_data, instruction_out;
    logic [1:0]  pc_sel, state_dbg;
    logic [4:0]  wb_reg;

    int n_checks = 0;
    int n_errors = 0;

    memory_stage dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .alu_out(alu_out),
        .z_in(z_in), .bne_in(bne_in), .branch_in(branch_in),
        .branch_addr(branch_addr), .read_dat1(read_dat1), .read_dat2(read_dat2),
        .write_reg(write_reg), .jr_flag(jr_flag), .j_jal_flag(j_jal_flag),
        .jal_flag(jal_flag), .lui_flag(lui_flag), .memtoreg(memtoreg),
        .mem_read(mem_read), .mem_write(mem_write), .regWEN(regWEN), .halt(halt),
        .j_jal_addr(j_jal_addr), .lower_zero(lower_zero), .pc4(pc4),
        .instruction(instruction), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .pc_sel(pc_sel),
        .pc_target(pc_target), .flush(flush), .wb_data(wb_data),
        .wb_reg(wb_reg), .wb_wen(wb_wen), .halt_out(halt_out),
        .instruction_out(instruction_out), .state_dbg(state_dbg)
    );

    // Clock: 10ns period.
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_bundle();
        in_valid = 0; alu_out = 0; z_in = 0; bne_in = 0; branch_in = 0;
        branch_addr = 0; read_dat1 = 0; read_dat2 = 0; write_reg = 0;
        jr_flag = 0; j_jal_flag = 0; jal_flag = 0; lui_flag = 0; memtoreg = 0;
        mem_read = 0; mem_write = 0; regWEN = 0; halt = 0;
        j_jal_addr = 0; lower_zero = 0; pc4 = 0; instruction = 0;
        dhit = 0; dmemload = 0;
    endtask

    initial begin
        clear_bundle();
        nRST = 0;
        repeat (2) @(negedge CLK);
        // reset state
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_reg", {27'd0, wb_reg}, 0);
        check("rst_wb_wen", {31'd0, wb_wen}, 0);
        check("rst_halt", {31'd0, halt_out}, 0);
        check("rst_instr", instruction_out, 0);
        check("rst_ren", {31'd0, dmemREN}, 0);
        check("rst_stall", {31'd0, mem_stall}, 0);
        check("rst_pcsel", {30'd0, pc_sel}, 0);
        check("rst_state", {30'd0, state_dbg}, 0);
        nRST = 1;
        @(negedge CLK);

        // add
        in_valid = 1; alu_out = 32'h10; write_reg = 5'd8; regWEN = 1;
        pc4 = 32'h4; instruction = 32'h0109_4020;
        #1;
        check("add_stall", {31'd0, mem_stall}, 0);
        check("add_pcsel", {30'd0, pc_sel}, 0);
        check("add_flush", {31'd0, flush}, 0);
        check("add_target", pc_target, 32'h4);
        @(negedge CLK);
        check("add_wb_data", wb_data, 32'h10);
        check("add_wb_reg", {27'd0, wb_reg}, 8);
        check("add_wb_wen", {31'd0, wb_wen}, 1);
        check("add_instr", instruction_out, 32'h0109_4020);
        clear_bundle();
        @(negedge CLK);
        check("idle_wb_wen", {31'd0, wb_wen}, 0);
        check("idle_wb_hold", wb_data, 32'h10);

        // lw, dhit on the third ACCESS cycle
        in_valid = 1; mem_read = 1; memtoreg = 1; regWEN = 1;
        alu_out = 32'h100; write_reg = 5'd9; instruction = 32'h8D09_0100;
        #1;
        check("lw_no_redirect", {30'd0, pc_sel}, 0);
        check("lw_idle_wen", {31'd0, wb_wen}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 2) begin
                dhit = 1; dmemload = 32'hDEAD_BEEF;
            end
            #1;
            check("lw_ren", {31'd0, dmemREN}, 1);
            check("lw_wen_req", {31'd0, dmemWEN}, 0);
            check("lw_addr", dmemaddr, 32'h100);
            check("lw_stall", {31'd0, mem_stall}, (i == 2) ? 0 : 1);
            check("lw_state", {30'd0, state_dbg}, 1);
            check("lw_wb_wen_busy", {31'd0, wb_wen}, 0);
        end
        @(negedge CLK);
        clear_bundle();
        check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        check("lw_wb_reg", {27'd0, wb_reg}, 9);
        check("lw_wb_wen", {31'd0, wb_wen}, 1);
        check("lw_instr", instruction_out, 32'h8D09_0100);
        check("lw_back_idle", {30'd0, state_dbg}, 0);
        check("lw_ren_off", {31'd0, dmemREN}, 0);

        // sw, dhit on the first ACCESS cycle
        in_valid = 1; mem_write = 1; read_dat2 = 32'h1234; alu_out = 32'h200;
        @(negedge CLK);
        dhit = 1;
        #1;
        check("sw_wen_req", {31'd0, dmemWEN}, 1);
        check("sw_ren", {31'd0, dmemREN}, 0);
        check("sw_store", dmemstore, 32'h1234);
        check("sw_addr", dmemaddr, 32'h200);
        check("sw_stall", {31'd0, mem_stall}, 0);
        @(negedge CLK);
        clear_bundle();
        check("sw_wb_wen", {31'd0, wb_wen}, 0);
        check("sw_state", {30'd0, state_dbg}, 0);

        // bne taken
        in_valid = 1; branch_in = 1; bne_in = 1; z_in = 0;
        branch_addr = 32'h40; pc4 = 32'h30;
        #1;
        check("bne_pcsel", {30'd0, pc_sel}, 1);
        check("bne_target", pc_target, 32'h40);
        check("bne_flush", {31'd0, flush}, 1);
        // beq not taken
        bne_in = 0; z_in = 0;
        #1;
        check("beq_nt_pcsel", {30'd0, pc_sel}, 0);
        check("beq_nt_flush", {31'd0, flush}, 0);
        check("beq_nt_target", pc_target, 32'h30);
        // beq taken
        z_in = 1;
        #1;
        check("beq_t_pcsel", {30'd0, pc_sel}, 1);
        // jr outranks j/jal and branch
        jr_flag = 1; j_jal_flag = 1; read_dat1 = 32'h300; j_jal_addr = 32'h80;
        #1;
        check("jr_pcsel", {30'd0, pc_sel}, 2);
        check("jr_target", pc_target, 32'h300);
        @(negedge CLK);
        clear_bundle();

        // jal
        in_valid = 1; j_jal_flag = 1; jal_flag = 1; regWEN = 1;
        pc4 = 32'h24; j_jal_addr = 32'h80; write_reg = 5'd5; alu_out = 32'h77;
        #1;
        check("jal_pcsel", {30'd0, pc_sel}, 3);
        check("jal_target", pc_target, 32'h80);
        check("jal_flush", {31'd0, flush}, 1);
        @(negedge CLK);
        check("jal_wb_reg", {27'd0, wb_reg}, 31);
        check("jal_wb_data", wb_data, 32'h24);
        check("jal_wb_wen", {31'd0, wb_wen}, 1);
        clear_bundle();

        // lui
        in_valid = 1; lui_flag = 1; regWEN = 1; lower_zero = 32'hABCD_0000;
        write_reg = 5'd3; alu_out = 32'h55;
        @(negedge CLK);
        check("lui_wb_data", wb_data, 32'hABCD_0000);
        check("lui_wb_reg", {27'd0, wb_reg}, 3);
        clear_bundle();

        // reset in the middle of an access
        in_valid = 1; mem_read = 1; memtoreg = 1; regWEN = 1;
        alu_out = 32'h180; write_reg = 5'd10;
        @(negedge CLK);
        #1;
        check("rmid_ren_before", {31'd0, dmemREN}, 1);
        #1 nRST = 0;
        #1;
        check("rmid_ren", {31'd0, dmemREN}, 0);
        check("rmid_stall", {31'd0, mem_stall}, 0);
        check("rmid_wb_data", wb_data, 0);
        check("rmid_wb_reg", {27'd0, wb_reg}, 0);
        check("rmid_wb_wen", {31'd0, wb_wen}, 0);
        check("rmid_state", {30'd0, state_dbg}, 0);
        clear_bundle();
        @(negedge CLK);
        nRST = 1;
        dhit = 1; dmemload = 32'hFFFF_FFFF;
        @(negedge CLK);
        check("idle_dhit_wen", {31'd0, wb_wen}, 0);
        check("idle_dhit_data", wb_data, 0);
        clear_bundle();

        // halt
        in_valid = 1; halt = 1; regWEN = 1; alu_out = 32'h99; write_reg = 5'd4;
        @(negedge CLK);
        check("halt_out", {31'd0, halt_out}, 1);
        check("halt_wb_wen", {31'd0, wb_wen}, 0);
        check("halt_state", {30'd0, state_dbg}, 2);
        clear_bundle();
        // later load with dhit pulses must be ignored
        in_valid = 1; mem_read = 1; memtoreg = 1; regWEN = 1; alu_out = 32'h400;
        jr_flag = 1; read_dat1 = 32'h500;
        for (int i = 0; i < 3; i++) begin
            dhit = (i != 1); dmemload = 32'h1357_9BDF;
            #1;
            check("halted_ren", {31'd0, dmemREN}, 0);
            check("halted_stall", {31'd0, mem_stall}, 0);
            check("halted_pcsel", {30'd0, pc_sel}, 0);
            @(negedge CLK);
            check("halted_sticky", {31'd0, halt_out}, 1);
            check("halted_wb_wen", {31'd0, wb_wen}, 0);
            check("halted_state", {30'd0, state_dbg}, 2);
        end
        check("halted_wb_data", wb_data, 0);
        clear_bundle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
